gsm_frame_scheduler: RTL

- Ping-pong frame controller in front of the Gsm_LPC_Analysis core.
- Accepts a 16-bit speech-sample stream into two FRAME_LEN-word banks of a shared dual-port sample RAM.
- Starts the core on each full bank using the ap_start/ap_ready/ap_done handshake, and arbitrates the shared RAM port between the sample loader and the core.
- Signals per-frame completion to the downstream encoder.

---
 rtl/gsm_frame_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/gsm_frame_scheduler.sv
// Ping-pong frame scheduler for the Gsm_LPC_Analysis core: fills two sample banks,
// runs the core on each full bank and arbitrates the shared RAM port1.
module gsm_frame_scheduler #(
  parameter int FRAME_LEN = 160,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              enable,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  output logic              smp_ready,
  output logic              core_ap_start,
  input  logic              core_ap_ready,
  input  logic              core_ap_done,
  input  logic [ADDR_W-1:0] core_address0,
  input  logic              core_ce0,
  input  logic              core_we0,
  input  logic [DATA_W-1:0] core_d0,
  input  logic [ADDR_W-1:0] core_address1,
  input  logic              core_ce1,
  input  logic              core_we1,
  input  logic [DATA_W-1:0] core_d1,
  output logic [ADDR_W:0]   mem_address0,
  output logic              mem_ce0,
  output logic              mem_we0,
  output logic [DATA_W-1:0] mem_d0,
  output logic [ADDR_W:0]   mem_address1,
  output logic              mem_ce1,
  output logic              mem_we1,
  output logic [DATA_W-1:0] mem_d1,
  output logic              frame_done,
  output logic              frame_bank,
  output logic [15:0]       frame_count,
  output logic              busy
);

  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_BUSY} bank_st_e;
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} sched_st_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  bank_st_e          bank_q [2];
  bank_st_e          bank_d [2];
  sched_st_e         state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              ld_ok_q, ld_ok_d;
  logic              start_q, start_d;
  logic              fdone_q, fdone_d;
  logic              fbank_q, fbank_d;
  logic [15:0]       fcount_q, fcount_d;
  logic              busy_q;
  logic              accept;
  logic              finish;

  // Bank availability is registered; the core_ce1 term must stay combinational so
  // a loader write can never collide with a core access on port1.
  assign smp_ready = ld_ok_q & ~core_ce1;
  assign accept    = smp_valid & smp_ready;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    bank_d    = bank_q;
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    start_d   = start_q;
    fdone_d   = 1'b0;
    fbank_d   = fbank_q;
    fcount_d  = fcount_q;
    finish    = 1'b0;

    // Loader only touches an EMPTY/FILL bank, scheduler only a FULL/BUSY one.
    if (accept) begin
      if (wr_cnt_q == LAST_IDX) begin
        bank_d[wr_bank_q] = B_FULL;
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = B_FILL;
        wr_cnt_d          = wr_cnt_q + ADDR_W'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable && bank_q[rd_bank_q] == B_FULL) begin
          state_d           = S_START;
          start_d           = 1'b1;
          bank_d[rd_bank_q] = B_BUSY;
        end
      end
      S_START: begin
        if (core_ap_ready) begin
          start_d = 1'b0;
          if (core_ap_done) finish = 1'b1;
          else              state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (core_ap_done) finish = 1'b1;
      end
      S_DONE: begin
        bank_d[rd_bank_q] = B_EMPTY;
        rd_bank_d         = ~rd_bank_q;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d  = S_DONE;
      fdone_d  = 1'b1;
      fbank_d  = rd_bank_q;
      fcount_d = fcount_q + 16'd1;
    end

    ld_ok_d = (bank_d[wr_bank_d] == B_EMPTY) || (bank_d[wr_bank_d] == B_FILL);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      bank_q    <= '{default: B_EMPTY};
      state_q   <= S_IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      ld_ok_q   <= 1'b0;
      start_q   <= 1'b0;
      fdone_q   <= 1'b0;
      fbank_q   <= 1'b0;
      fcount_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      ld_ok_q   <= ld_ok_d;
      start_q   <= start_d;
      fdone_q   <= fdone_d;
      fbank_q   <= fbank_d;
      fcount_q  <= fcount_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign core_ap_start = start_q;
  assign frame_done    = fdone_q;
  assign frame_bank    = fbank_q;
  assign frame_count   = fcount_q;
  assign busy          = busy_q;

  assign mem_address0 = {rd_bank_q, core_address0};
  assign mem_ce0      = core_ce0;
  assign mem_we0      = core_we0;
  assign mem_d0       = core_d0;

  // Core has fixed priority on port1.
  always_comb begin
    mem_address1 = '0;
    mem_ce1      = 1'b0;
    mem_we1      = 1'b0;
    mem_d1       = '0;
    if (core_ce1) begin
      mem_address1 = {rd_bank_q, core_address1};
      mem_ce1      = 1'b1;
      mem_we1      = core_we1;
      mem_d1       = core_d1;
    end else if (accept) begin
      mem_address1 = {wr_bank_q, wr_cnt_q};
      mem_ce1      = 1'b1;
      mem_we1      = 1'b1;
      mem_d1       = smp_data;
    end
  end

endmodule
